// File: rtl/pc_fetch_redirect_pkg.sv
// Shared types and constants for the PC owner / fetch redirect block.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR             = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR    = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR     = 32'h0000_0100;
  localparam int unsigned DEF_FLUSH_DEPTH     = 2;

endpackage

// File: rtl/pc_fetch_redirect_squash_counter.sv
// Squash counter: loads the flush depth on a redirect and counts down;
// the IF/ID flush is asserted while the count is non-zero.
module fetch_squash_counter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active
);

  localparam logic [2:0] DEPTH3 = 3'(DEPTH);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
    end else if (load) begin
      count <= DEPTH3;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign active = (count != 3'd0);

endmodule

// File: rtl/pc_fetch_redirect.sv
// PC owner and fetch sequencer with EX-stage redirect, busy-deferred redirects
// and wrong-path squash. Optional misaligned-target trap: define MISALIGN_TRAP_EN.
module pc_fetch_redirect
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int unsigned FLUSH_DEPTH  = DEF_FLUSH_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_busy,
  input  logic        redirect,
  input  logic [31:0] target_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_exc,
  output logic [31:0] exc_addr
);

`ifdef MISALIGN_TRAP_EN
  localparam bit MISALIGN_ON = 1'b1;
`else
  localparam bit MISALIGN_ON = 1'b0;
`endif

  function automatic logic is_misaligned(input logic [31:0] addr);
    return MISALIGN_ON && (addr[1:0] != 2'b00);
  endfunction

  // Without the trap the low bits are simply dropped.
  function automatic logic [31:0] resolve_target(input logic [31:0] addr);
    return is_misaligned(addr) ? TRAP_VECTOR : {addr[31:2], 2'b00};
  endfunction

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  pend_tgt, pend_nxt;
  logic [31:0]  src;
  logic         apply;
  logic         load_sq;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_tgt;
    apply     = 1'b0;
    load_sq   = 1'b0;
    src       = redirect ? target_addr : pend_tgt;
    if (redirect) begin
      load_sq = 1'b1;
      if (imem_busy) begin
        state_nxt = PEND;
        pend_nxt  = target_addr;
      end else begin
        state_nxt = RUN;
        apply     = 1'b1;
      end
    end else begin
      case (state)
        BOOT: state_nxt = RUN;
        PEND: begin
          if (!imem_busy) begin
            state_nxt = RUN;
            apply     = 1'b1;
          end
        end
        default: begin
          if (!imem_busy && !stall) pc_nxt = pc + PC_INCR;
        end
      endcase
    end
    if (apply) pc_nxt = resolve_target(src);
  end

  // Edge: PC, state and the single-cycle ID/EX squash
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      flush_idex <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      flush_idex <= load_sq;
    end
  end

  // Pending target is data; its validity lives in the PEND state.
  always_ff @(posedge clk) begin
    pend_tgt <= pend_nxt;
  end

  fetch_squash_counter #(
    .DEPTH (FLUSH_DEPTH)
  ) u_squash (
    .clk    (clk),
    .reset  (reset),
    .load   (load_sq),
    .active (flush_ifid)
  );

`ifdef MISALIGN_TRAP_EN
  logic exc_fire;
  assign exc_fire = apply && is_misaligned(src);

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_exc <= 1'b0;
      exc_addr     <= 32'h0;
    end else begin
      misalign_exc <= exc_fire;
      if (exc_fire) exc_addr <= src;
    end
  end
`else
  assign misalign_exc = 1'b0;
  assign exc_addr     = 32'h0;
`endif

  assign fetch_valid = (state == RUN);
  assign pc_plus4    = pc + PC_INCR;

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// Bench for pc_fetch_redirect: directed vector table, a pending-misalign sequence,
// and randomized traffic against a behavioural model.
module tb_pc_fetch_redirect;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          FD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, imem_busy = 1'b0, redirect = 1'b0;
  logic [31:0] target_addr = 32'h0;
  logic [31:0] pc, pc_plus4, exc_addr;
  logic        fetch_valid, flush_ifid, flush_idex, misalign_exc;

  int n_chk = 0;
  int n_err = 0;

  pc_fetch_redirect dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .imem_busy    (imem_busy),
    .redirect     (redirect),
    .target_addr  (target_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_exc (misalign_exc),
    .exc_addr     (exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r, s, b, d;
    logic [31:0] t;
    logic [31:0] pc;
    bit          fv, ifid, idex, exc;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit b, input bit d, input logic [31:0] t);
    reset = r; stall = s; imem_busy = b; redirect = d; target_addr = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, s, b, d, input logic [31:0] t, input logic [31:0] epc,
                     input bit fv, ifid, idex, exc, input logic [31:0] ea);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.d = d; v.t = t; v.pc = epc;
    v.fv = fv; v.ifid = ifid; v.idex = idex; v.exc = exc; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic v(input bit r, s, b, d, input logic [31:0] t, input logic [31:0] epc,
                   input bit fv, ifid, idex);
    add(r, s, b, d, t, epc, fv, ifid, idex, 1'b0, 32'h0);
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input bit fv, ifid, idex,
                           input bit exc, input logic [31:0] ea);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
    chk({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, fv});
    chk({tag, ".flush_ifid"}, {31'b0, flush_ifid}, {31'b0, ifid});
    chk({tag, ".flush_idex"}, {31'b0, flush_idex}, {31'b0, idex});
    chk({tag, ".misalign_exc"}, {31'b0, misalign_exc}, {31'b0, exc});
    chk({tag, ".exc_addr"}, exc_addr, ea);
  endtask

  // Behavioural model: "started" = out of boot, "waiting" = redirect deferred by busy memory.
  logic [31:0] m_pc, m_wait_tgt, m_ea;
  bit          m_started, m_waiting, m_idex, m_exc;
  int          m_squash;

  task automatic m_load(input logic [31:0] t);
    if (TRAP && t[1:0] != 2'b00) begin
      m_pc = TV; m_exc = 1'b1; m_ea = t;
    end else begin
      m_pc = t & 32'hFFFF_FFFC;
    end
  endtask

  task automatic m_step(input bit r, s, b, d, input logic [31:0] t);
    if (r) begin
      m_pc = RV; m_started = 0; m_waiting = 0; m_squash = 0;
      m_idex = 0; m_exc = 0; m_ea = 32'h0;
    end else begin
      m_idex = 0; m_exc = 0;
      if (m_squash > 0) m_squash--;
      if (d) begin
        m_squash = FD; m_idex = 1; m_started = 1;
        if (b) begin
          m_waiting = 1; m_wait_tgt = t;
        end else begin
          m_waiting = 0; m_load(t);
        end
      end else if (m_waiting) begin
        if (!b) begin
          m_waiting = 0; m_load(m_wait_tgt);
        end
      end else if (!m_started) begin
        m_started = 1;
      end else if (!b && !s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    // r s b d target         pc           fv if ix
    v(1,0,0,0,32'h0,          32'h0,       0,0,0);
    v(1,0,0,0,32'h0,          32'h0,       0,0,0);
    v(0,0,0,0,32'h0,          32'h0,       1,0,0);
    v(0,0,0,0,32'h0,          32'h4,       1,0,0);
    v(0,0,0,0,32'h0,          32'h8,       1,0,0);
    v(0,0,0,0,32'h0,          32'hC,       1,0,0);
    v(0,0,0,0,32'h0,          32'h10,      1,0,0);
    v(0,0,0,1,32'h40,         32'h40,      1,1,1);
    v(0,0,0,0,32'h0,          32'h44,      1,1,0);
    v(0,0,0,0,32'h0,          32'h48,      1,0,0);
    v(0,0,1,1,32'h80,         32'h48,      0,1,1);
    v(0,0,1,0,32'h0,          32'h48,      0,1,0);
    v(0,0,1,0,32'h0,          32'h48,      0,0,0);
    v(0,0,0,0,32'h0,          32'h80,      1,0,0);
    v(0,0,0,0,32'h0,          32'h84,      1,0,0);
    v(0,1,0,1,32'h200,        32'h200,     1,1,1);
    v(0,1,0,0,32'h0,          32'h200,     1,1,0);
    v(0,1,0,0,32'h0,          32'h200,     1,0,0);
    v(0,0,0,0,32'h0,          32'h204,     1,0,0);
    v(0,0,0,1,32'h204,        32'h204,     1,1,1);
    v(0,0,0,0,32'h0,          32'h208,     1,1,0);
    v(0,0,0,1,32'h300,        32'h300,     1,1,1);
    v(0,0,0,0,32'h0,          32'h304,     1,1,0);
    v(0,0,0,0,32'h0,          32'h308,     1,0,0);
    v(0,0,1,0,32'h0,          32'h308,     1,0,0);
    v(0,0,0,0,32'h0,          32'h30C,     1,0,0);
    v(0,0,0,1,32'hFFFF_FFFC,  32'hFFFF_FFFC,1,1,1);
    v(0,0,0,0,32'h0,          32'h0,       1,1,0);
    v(0,0,0,0,32'h0,          32'h4,       1,0,0);
    v(0,0,1,1,32'h500,        32'h4,       0,1,1);
    v(1,0,1,0,32'h0,          32'h0,       0,0,0);
    v(0,0,1,0,32'h0,          32'h0,       1,0,0);
    v(0,0,0,0,32'h0,          32'h4,       1,0,0);
    v(1,0,0,0,32'h0,          32'h0,       0,0,0);
    v(0,0,0,1,32'h600,        32'h600,     1,1,1);
    v(0,0,0,0,32'h0,          32'h604,     1,1,0);
    v(0,0,0,0,32'h0,          32'h608,     1,0,0);
    v(0,0,1,1,32'h700,        32'h608,     0,1,1);
    v(0,0,1,1,32'h800,        32'h608,     0,1,1);
    v(0,0,1,0,32'h0,          32'h608,     0,1,0);
    v(0,0,0,0,32'h0,          32'h800,     1,0,0);
    add(0,0,0,1,32'h102,      32'h100,     1,1,1, TRAP, TRAP ? 32'h102 : 32'h0);
    add(0,0,0,0,32'h0,        32'h104,     1,1,0, 1'b0, TRAP ? 32'h102 : 32'h0);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].d, vecs[i].t);
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].ifid,
                vecs[i].idex, vecs[i].exc, vecs[i].ea);
    end

    // Misaligned target deferred by a busy memory, applied when busy drops.
    cyc(0,0,1,1,32'h207);
    check_all("pendmis_a", 32'h104, 0, 1, 1, 1'b0, TRAP ? 32'h102 : 32'h0);
    cyc(0,0,0,0,32'h0);
    check_all("pendmis_b", TRAP ? 32'h100 : 32'h204, 1, 1, 0, TRAP, TRAP ? 32'h207 : 32'h0);

    // Randomized traffic against the model.
    cyc(1,0,0,0,32'h0);
    m_step(1,0,0,0,32'h0);
    check_all("rnd_reset", m_pc, 0, 0, 0, 1'b0, 32'h0);
    for (int i = 0; i < 800; i++) begin
      bit r, s, b, d;
      logic [31:0] t;
      int sel;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 9);
      t = $urandom;
      if (sel < 6) t = t & 32'hFFFF_FFFC;
      else if (sel == 6) t = 32'hFFFF_FFFC;
      else if (sel == 7) t = m_pc;
      cyc(r, s, b, d, t);
      m_step(r, s, b, d, t);
      check_all($sformatf("rnd%0d", i), m_pc, m_started && !m_waiting, m_squash > 0,
                m_idex, m_exc, m_ea);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
